ram2_ctrl: RTL

Bus controller for the external RAM2 SRAM, which holds both instructions and data. It sits directly upstream of the RAM2 device and serialises two requesters: the IF stage (instruction fetch by PC) and the MEM stage (load/store). Each access becomes a registered multi-cycle SRAM bus cycle, and the controller raises a stall request while either requester is waiting.

---
 rtl/ram2_ctrl_if.sv | 23 ++
 rtl/ram2_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ram2_ctrl_if.sv
// Requester-side bundle for ram2_ctrl: the IF fetch handshake and the MEM load/store handshake.
interface ram2_ctrl_if;
  logic        if_req_i;
  logic [15:0] pc_i;
  logic [15:0] inst_o;
  logic        inst_valid_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [15:0] mem_addr_i;
  logic [15:0] mem_data_i;
  logic [15:0] mem_data_o;
  logic        mem_ready_o;

  modport master (
    output if_req_i, pc_i, mem_ce_i, mem_we_i, mem_addr_i, mem_data_i,
    input  inst_o, inst_valid_o, mem_data_o, mem_ready_o
  );

  modport slave (
    input  if_req_i, pc_i, mem_ce_i, mem_we_i, mem_addr_i, mem_data_i,
    output inst_o, inst_valid_o, mem_data_o, mem_ready_o
  );
endinterface

// File: rtl/ram2_ctrl.sv
// RAM2 SRAM controller serialising instruction fetch and MEM load/store into registered bus cycles.
// Optional one-entry instruction buffer enabled by defining RAM2_IBUF_EN.
module ram2_ctrl #(
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  ram2_ctrl_if.slave  bus,
  output logic        stall_req_o,
  output logic [17:0] ram2_addr_o,
  inout  wire  [15:0] ram2_data_io,
  output logic        ram2_en_n_o,
  output logic        ram2_oe_n_o,
  output logic        ram2_we_n_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_IF, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] addr_reg, addr_next;
  logic [15:0] wdata_reg, wdata_next;
  logic [15:0] inst_reg, inst_next;
  logic [15:0] mem_data_reg, mem_data_next;
  logic        inst_valid_reg, inst_valid_next;
  logic        mem_ready_reg, mem_ready_next;
  logic        en_n_reg, en_n_next;
  logic        oe_n_reg, oe_n_next;
  logic        we_n_reg, we_n_next;
  logic        drive_reg, drive_next;
`ifdef RAM2_IBUF_EN
  logic        ibuf_valid_reg, ibuf_valid_next;
  logic [15:0] ibuf_tag_reg, ibuf_tag_next;
  logic [15:0] ibuf_data_reg, ibuf_data_next;
  logic        ibuf_hit;
  assign ibuf_hit = ibuf_valid_reg && (ibuf_tag_reg == bus.pc_i);
`endif

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    inst_next       = inst_reg;
    mem_data_next   = mem_data_reg;
    inst_valid_next = 1'b0;
    mem_ready_next  = 1'b0;
`ifdef RAM2_IBUF_EN
    ibuf_valid_next = ibuf_valid_reg;
    ibuf_tag_next   = ibuf_tag_reg;
    ibuf_data_next  = ibuf_data_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        // MEM has priority over IF when both are requesting
        if (bus.mem_ce_i) begin
          addr_next = bus.mem_addr_i;
          if (bus.mem_we_i) begin
            state_next = S_WR_SETUP;
            wdata_next = bus.mem_data_i;
`ifdef RAM2_IBUF_EN
            ibuf_valid_next = 1'b0;
`endif
          end else begin
            state_next = S_RD;
          end
        end else if (bus.if_req_i) begin
`ifdef RAM2_IBUF_EN
          if (ibuf_hit) begin
            state_next      = S_DONE;
            inst_next       = ibuf_data_reg;
            inst_valid_next = 1'b1;
          end else begin
            state_next = S_IF;
            addr_next  = bus.pc_i;
          end
`else
          state_next = S_IF;
          addr_next  = bus.pc_i;
`endif
        end
      end
      S_IF: begin
        state_next      = S_DONE;
        inst_next       = ram2_data_io;
        inst_valid_next = 1'b1;
`ifdef RAM2_IBUF_EN
        ibuf_valid_next = 1'b1;
        ibuf_tag_next   = addr_reg;
        ibuf_data_next  = ram2_data_io;
`endif
      end
      S_RD: begin
        state_next     = S_DONE;
        mem_data_next  = ram2_data_io;
        mem_ready_next = 1'b1;
      end
      S_WR_SETUP: state_next = S_WR_PULSE;
      S_WR_PULSE: state_next = S_WR_HOLD;
      S_WR_HOLD: begin
        state_next     = S_DONE;
        mem_ready_next = 1'b1;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    // Bus strobes are registered from the state being entered, so they line up with it
    en_n_next  = !(state_next inside {S_IF, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
    oe_n_next  = !(state_next inside {S_IF, S_RD});
    we_n_next  = (state_next != S_WR_PULSE);
    drive_next = (state_next inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      inst_reg       <= NOP_INST;
      mem_data_reg   <= '0;
      inst_valid_reg <= 1'b0;
      mem_ready_reg  <= 1'b0;
      en_n_reg       <= 1'b1;
      oe_n_reg       <= 1'b1;
      we_n_reg       <= 1'b1;
      drive_reg      <= 1'b0;
`ifdef RAM2_IBUF_EN
      ibuf_valid_reg <= 1'b0;
      ibuf_tag_reg   <= '0;
      ibuf_data_reg  <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      inst_reg       <= inst_next;
      mem_data_reg   <= mem_data_next;
      inst_valid_reg <= inst_valid_next;
      mem_ready_reg  <= mem_ready_next;
      en_n_reg       <= en_n_next;
      oe_n_reg       <= oe_n_next;
      we_n_reg       <= we_n_next;
      drive_reg      <= drive_next;
`ifdef RAM2_IBUF_EN
      ibuf_valid_reg <= ibuf_valid_next;
      ibuf_tag_reg   <= ibuf_tag_next;
      ibuf_data_reg  <= ibuf_data_next;
`endif
    end
  end

  assign ram2_addr_o  = {2'b00, addr_reg};
  assign ram2_data_io = drive_reg ? wdata_reg : 16'hzzzz;
  assign ram2_en_n_o  = en_n_reg;
  assign ram2_oe_n_o  = oe_n_reg;
  assign ram2_we_n_o  = we_n_reg;

  assign bus.inst_o       = inst_reg;
  assign bus.inst_valid_o = inst_valid_reg;
  assign bus.mem_data_o   = mem_data_reg;
  assign bus.mem_ready_o  = mem_ready_reg;

  assign stall_req_o = (bus.mem_ce_i & ~mem_ready_reg) | (bus.if_req_i & ~inst_valid_reg);

endmodule
